// File: rtl/exec_pkg.sv
// Shared EXEC-stage definitions: complex-ALU opcodes, flag layout and FSM states.
package exec_pkg;

    // Complex-issue opcodes
    localparam logic [5:0] MULT_L  = 6'h18;
    localparam logic [5:0] MULT_H  = 6'h19;
    localparam logic [5:0] MULTU_L = 6'h1A;
    localparam logic [5:0] MULTU_H = 6'h1B;
    localparam logic [5:0] DIV_L   = 6'h1C;
    localparam logic [5:0] DIV_H   = 6'h1D;
    localparam logic [5:0] DIVU_L  = 6'h1E;
    localparam logic [5:0] DIVU_H  = 6'h1F;
    localparam logic [5:0] SYSCALL = 6'h0C;

    // Bit positions inside flags {rsvd, wr_en, lo_sel, executed, exception, mispredict}
    localparam int unsigned FLAG_RSVD       = 5;
    localparam int unsigned FLAG_WR_EN      = 4;
    localparam int unsigned FLAG_LO_SEL     = 3;
    localparam int unsigned FLAG_EXECUTED   = 2;
    localparam int unsigned FLAG_EXCEPTION  = 1;
    localparam int unsigned FLAG_MISPREDICT = 0;

    // Per-op flag words
    localparam logic [5:0] FLAGS_LO  = 6'b011100;
    localparam logic [5:0] FLAGS_HI  = 6'b010100;
    localparam logic [5:0] FLAGS_SYS = 6'b000110;

    typedef enum logic [1:0] {
        StIdle,
        StBusy,
        StFix,
        StDone
    } state_e;

    typedef struct packed {
        logic known;
        logic sys;
        logic div;
        logic sgn;
        logic hi;
    } op_dec_t;

    // Split an opcode into the control bits the iterative unit needs
    function automatic op_dec_t decode_op(input logic [5:0] opc);
        op_dec_t d;
        d       = '0;
        d.known = 1'b1;
        case (opc)
            MULT_L:  d.sgn = 1'b1;
            MULT_H:  begin d.sgn = 1'b1; d.hi = 1'b1; end
            MULTU_L: d.hi = 1'b0;
            MULTU_H: d.hi = 1'b1;
            DIV_L:   begin d.div = 1'b1; d.sgn = 1'b1; end
            DIV_H:   begin d.div = 1'b1; d.sgn = 1'b1; d.hi = 1'b1; end
            DIVU_L:  d.div = 1'b1;
            DIVU_H:  begin d.div = 1'b1; d.hi = 1'b1; end
            SYSCALL: d.sys = 1'b1;
            default: d.known = 1'b0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/iter_muldiv_step.sv
// One radix-2 iteration: shift/add multiply step or restoring-divide step.
// Multiply: {acc_hi, acc_lo} holds {partial product, remaining multiplier}, shifts right.
// Divide:   {acc_hi, acc_lo} holds {partial remainder, dividend/quotient}, shifts left.
module iter_muldiv_step #(
    parameter int unsigned DATA_W = 32
) (
    input  logic              is_div_i,
    input  logic [DATA_W-1:0] acc_hi_i,
    input  logic [DATA_W-1:0] acc_lo_i,
    input  logic [DATA_W-1:0] operand_i,
    output logic [DATA_W-1:0] acc_hi_o,
    output logic [DATA_W-1:0] acc_lo_o
);

    logic [DATA_W:0]   mul_sum;
    logic [DATA_W:0]   div_shift;
    logic              div_ge;
    logic [DATA_W-1:0] div_diff;

    // Both step flavours computed in parallel, selected by operation type
    always_comb begin
        mul_sum   = {1'b0, acc_hi_i} + (acc_lo_i[0] ? {1'b0, operand_i} : '0);
        div_shift = {acc_hi_i, acc_lo_i[DATA_W-1]};
        div_ge    = div_shift >= {1'b0, operand_i};
        // Only used when div_ge, where the true difference always fits DATA_W bits
        div_diff  = div_shift[DATA_W-1:0] - operand_i;
        if (is_div_i) begin
            acc_hi_o = div_ge ? div_diff : div_shift[DATA_W-1:0];
            acc_lo_o = {acc_lo_i[DATA_W-2:0], div_ge};
        end else begin
            acc_hi_o = mul_sum[DATA_W:1];
            acc_lo_o = {mul_sum[0], acc_lo_i[DATA_W-1:1]};
        end
    end

endmodule

// File: rtl/complex_alu_iter.sv
// Multi-cycle complex ALU: signed/unsigned multiply, divide and remainder via a
// radix-2 iterative datapath, single-cycle SYSCALL, valid/ready in, pulse out, flush.
module complex_alu_iter
    import exec_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned TAG_W  = 7,
    parameter int unsigned OPC_W  = 6
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              flush_i,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [OPC_W-1:0]  opcode_i,
    input  logic [DATA_W-1:0] data1_i,
    input  logic [DATA_W-1:0] data2_i,
    input  logic [TAG_W-1:0]  tag_i,
    output logic              valid_o,
    output logic [DATA_W-1:0] result_o,
    output logic [5:0]        flags_o,
    output logic [TAG_W-1:0]  tag_o
);

    localparam int unsigned CntW = $clog2(DATA_W);

    state_e              state_q, state_d;
    logic [OPC_W-1:0]    opcode_q;
    logic [TAG_W-1:0]    op_tag_q;
    logic [DATA_W-1:0]   op_a_q, op_b_q;
    logic                sign_p_q, sign_r_q;
    logic [DATA_W-1:0]   acc_hi_q, acc_lo_q;
    logic [DATA_W-1:0]   acc_hi_d, acc_lo_d;
    logic [CntW-1:0]     cnt_q;
    logic [DATA_W-1:0]   fix_q, fix_d;
    logic                valid_q;
    logic [DATA_W-1:0]   result_q;
    logic [5:0]          flags_q;
    logic [TAG_W-1:0]    tag_out_q;

    logic [5:0]          in_opc, cur_opc;
    logic                in_known, in_sys, in_div, in_sgn;
    logic                cur_known, cur_sys, cur_div, cur_hi;
    logic                a_neg, b_neg;
    logic [DATA_W-1:0]   a_abs, b_abs;
    logic                accept, last_step;
    logic                load_en, step_en, fix_en, emit;

    assign in_opc    = 6'(opcode_i);
    assign cur_opc   = 6'(opcode_q);
    assign in_known  = decode_op(in_opc).known;
    assign in_sys    = decode_op(in_opc).sys;
    assign in_div    = decode_op(in_opc).div;
    assign in_sgn    = decode_op(in_opc).sgn;
    assign cur_known = decode_op(cur_opc).known;
    assign cur_sys   = decode_op(cur_opc).sys;
    assign cur_div   = decode_op(cur_opc).div;
    assign cur_hi    = decode_op(cur_opc).hi;

    // Flush wins over an offer in the same cycle
    assign accept    = valid_i & ready_o & ~flush_i;
    assign last_step = cnt_q == CntW'(DATA_W - 1);

    // Operand magnitudes for signed ops; MIN stays MIN, which reads correctly as unsigned
    always_comb begin
        a_neg = in_sgn & data1_i[DATA_W-1];
        b_neg = in_sgn & data2_i[DATA_W-1];
        a_abs = a_neg ? -data1_i : data1_i;
        b_abs = b_neg ? -data2_i : data2_i;
    end

    // FSM state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: if (accept) state_d = (in_known && !in_sys) ? StBusy : StDone;
            StBusy: if (last_step) state_d = StFix;
            StFix:  state_d = StDone;
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
        if (flush_i && state_q != StIdle) begin
            state_d = StIdle;
        end
    end

    // FSM outputs and datapath enables
    always_comb begin
        ready_o = state_q == StIdle;
        load_en = accept;
        step_en = state_q == StBusy;
        fix_en  = state_q == StFix;
        emit    = (state_q == StDone) && !flush_i;
    end

    iter_muldiv_step #(
        .DATA_W(DATA_W)
    ) u_step (
        .is_div_i (cur_div),
        .acc_hi_i (acc_hi_q),
        .acc_lo_i (acc_lo_q),
        .operand_i(cur_div ? op_b_q : op_a_q),
        .acc_hi_o (acc_hi_d),
        .acc_lo_o (acc_lo_d)
    );

    // Sign correction and word select on the finished accumulator
    always_comb begin
        logic [2*DATA_W-1:0] prod;
        logic [DATA_W-1:0]   quo, rem;
        prod = {acc_hi_q, acc_lo_q};
        prod = sign_p_q ? -prod : prod;
        quo  = sign_p_q ? -acc_lo_q : acc_lo_q;
        rem  = sign_r_q ? -acc_hi_q : acc_hi_q;
        // Divide by zero: all-ones quotient, remainder is the original dividend
        if (op_b_q == '0) begin
            quo = '1;
            rem = sign_r_q ? -op_a_q : op_a_q;
        end
        if (cur_div) begin
            fix_d = cur_hi ? rem : quo;
        end else begin
            fix_d = cur_hi ? prod[2*DATA_W-1:DATA_W] : prod[DATA_W-1:0];
        end
    end

    // Operand capture, iteration and fix-up registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            opcode_q <= '0;
            op_tag_q <= '0;
            op_a_q   <= '0;
            op_b_q   <= '0;
            sign_p_q <= 1'b0;
            sign_r_q <= 1'b0;
            acc_hi_q <= '0;
            acc_lo_q <= '0;
            cnt_q    <= '0;
            fix_q    <= '0;
        end else if (load_en) begin
            opcode_q <= opcode_i;
            op_tag_q <= tag_i;
            op_a_q   <= a_abs;
            op_b_q   <= b_abs;
            sign_p_q <= a_neg ^ b_neg;
            sign_r_q <= a_neg;
            acc_hi_q <= '0;
            acc_lo_q <= in_div ? a_abs : b_abs;
            cnt_q    <= '0;
        end else if (step_en) begin
            acc_hi_q <= acc_hi_d;
            acc_lo_q <= acc_lo_d;
            cnt_q    <= cnt_q + 1'b1;
        end else if (fix_en) begin
            fix_q    <= fix_d;
        end
    end

    // Output registers: one-cycle valid pulse, payload held between pulses
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q   <= 1'b0;
            result_q  <= '0;
            flags_q   <= '0;
            tag_out_q <= '0;
        end else begin
            valid_q <= emit;
            if (emit) begin
                result_q  <= (cur_known && !cur_sys) ? fix_q : '0;
                flags_q   <= !cur_known ? 6'b000000 :
                             cur_sys    ? FLAGS_SYS :
                             cur_hi     ? FLAGS_HI  : FLAGS_LO;
                tag_out_q <= op_tag_q;
            end
        end
    end

    assign valid_o  = valid_q;
    assign result_o = result_q;
    assign flags_o  = flags_q;
    assign tag_o    = tag_out_q;

endmodule

// File: tb/tb_complex_alu_iter.sv
// Directed-vector bench for complex_alu_iter with hand-computed expectations.
module tb_complex_alu_iter;
    import exec_pkg::*;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned TAG_W  = 7;
    localparam int unsigned OPC_W  = 6;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              flush_i;
    logic              valid_i;
    logic              ready_o;
    logic [OPC_W-1:0]  opcode_i;
    logic [DATA_W-1:0] data1_i;
    logic [DATA_W-1:0] data2_i;
    logic [TAG_W-1:0]  tag_i;
    logic              valid_o;
    logic [DATA_W-1:0] result_o;
    logic [5:0]        flags_o;
    logic [TAG_W-1:0]  tag_o;

    int checks   = 0;
    int failures = 0;

    complex_alu_iter #(
        .DATA_W(DATA_W),
        .TAG_W (TAG_W),
        .OPC_W (OPC_W)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .flush_i (flush_i),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .opcode_i(opcode_i),
        .data1_i (data1_i),
        .data2_i (data2_i),
        .tag_i   (tag_i),
        .valid_o (valid_o),
        .result_o(result_o),
        .flags_o (flags_o),
        .tag_o   (tag_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    // Offer one op, then wait (bounded) for its valid_o pulse
    task automatic run_op(input logic [5:0] opc, input logic [31:0] a, input logic [31:0] b,
                          input logic [6:0] tag, output logic [31:0] res,
                          output logic [5:0] flg, output logic [6:0] tg, output int lat,
                          output logic rdy1);
        int waited;
        @(negedge clk);
        waited = 0;
        while (!ready_o && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        valid_i  = 1'b1;
        opcode_i = opc;
        data1_i  = a;
        data2_i  = b;
        tag_i    = tag;
        @(posedge clk);
        #1;
        valid_i = 1'b0;
        lat  = 0;
        res  = '0;
        flg  = '0;
        tg   = '0;
        rdy1 = 1'b0;
        while (lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
            if (lat == 1) rdy1 = ready_o;
            if (valid_o) begin
                res = result_o;
                flg = flags_o;
                tg  = tag_o;
                break;
            end
        end
    endtask

    task automatic do_test(input string name, input logic [5:0] opc, input logic [31:0] a,
                           input logic [31:0] b, input logic [6:0] tag,
                           input logic [31:0] exp_res, input logic [5:0] exp_flags,
                           input int exp_lat, input logic exp_rdy1);
        logic [31:0] res;
        logic [5:0]  flg;
        logic [6:0]  tg;
        int          lat;
        logic        rdy1;
        run_op(opc, a, b, tag, res, flg, tg, lat, rdy1);
        check({name, ".lat"},   64'(lat), 64'(exp_lat));
        check({name, ".res"},   64'(res), 64'(exp_res));
        check({name, ".flags"}, 64'(flg), 64'(exp_flags));
        check({name, ".tag"},   64'(tg),  64'(tag));
        check({name, ".rdy1"},  64'(rdy1), 64'(exp_rdy1));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        reset_n  = 1'b0;
        flush_i  = 1'b0;
        valid_i  = 1'b0;
        opcode_i = '0;
        data1_i  = '0;
        data2_i  = '0;
        tag_i    = '0;
        #1;
        check("rst.ready",  64'(ready_o),  64'd1);
        check("rst.valid",  64'(valid_o),  64'd0);
        check("rst.result", 64'(result_o), 64'd0);
        check("rst.flags",  64'(flags_o),  64'd0);
        check("rst.tag",    64'(tag_o),    64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;

        do_test("mult_l",   MULT_L,  32'hFFFF_FFF9, 32'd6, 7'd5, 32'hFFFF_FFD6, 6'b011100, 34, 1'b0);
        do_test("mult_h",   MULT_H,  32'hFFFF_FFF9, 32'd6, 7'd6, 32'hFFFF_FFFF, 6'b010100, 34, 1'b0);
        do_test("multu_h",  MULTU_H, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 7'd7, 32'hFFFF_FFFE, 6'b010100, 34, 1'b0);
        do_test("multu_l",  MULTU_L, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 7'd8, 32'h0000_0001, 6'b011100, 34, 1'b0);
        do_test("mult_hmin", MULT_H, 32'h8000_0000, 32'h8000_0000, 7'd9, 32'h4000_0000, 6'b010100, 34, 1'b0);
        do_test("div_l",    DIV_L,   32'hFFFF_FFEF, 32'd5, 7'd10, 32'hFFFF_FFFD, 6'b011100, 34, 1'b0);
        do_test("div_h",    DIV_H,   32'hFFFF_FFEF, 32'd5, 7'd11, 32'hFFFF_FFFE, 6'b010100, 34, 1'b0);
        do_test("divu_l",   DIVU_L,  32'hFFFF_FFEF, 32'd5, 7'd12, 32'h3333_332F, 6'b011100, 34, 1'b0);
        do_test("divu_h",   DIVU_H,  32'hFFFF_FFEF, 32'd5, 7'd13, 32'h0000_0004, 6'b010100, 34, 1'b0);
        do_test("divu0_l",  DIVU_L,  32'd100, 32'd0, 7'd14, 32'hFFFF_FFFF, 6'b011100, 34, 1'b0);
        do_test("divu0_h",  DIVU_H,  32'd100, 32'd0, 7'd15, 32'd100,       6'b010100, 34, 1'b0);
        do_test("div0_l",   DIV_L,   32'hFFFF_FFEF, 32'd0, 7'd16, 32'hFFFF_FFFF, 6'b011100, 34, 1'b0);
        do_test("div0_h",   DIV_H,   32'hFFFF_FFEF, 32'd0, 7'd17, 32'hFFFF_FFEF, 6'b010100, 34, 1'b0);
        do_test("ovf_l",    DIV_L,   32'h8000_0000, 32'hFFFF_FFFF, 7'd18, 32'h8000_0000, 6'b011100, 34, 1'b0);
        do_test("ovf_h",    DIV_H,   32'h8000_0000, 32'hFFFF_FFFF, 7'd19, 32'h0000_0000, 6'b010100, 34, 1'b0);
        do_test("syscall",  SYSCALL, 32'h1234_5678, 32'h9, 7'd20, 32'd0, 6'b000110, 1, 1'b1);
        do_test("unknown",  6'h00,   32'h1234_5678, 32'h9, 7'd21, 32'd0, 6'b000000, 1, 1'b1);

        // Flush ten cycles into a DIVU: no result, unit idle right after
        @(negedge clk);
        valid_i  = 1'b1;
        opcode_i = DIVU_L;
        data1_i  = 32'd1000;
        data2_i  = 32'd7;
        tag_i    = 7'd30;
        @(posedge clk);
        #1;
        valid_i = 1'b0;
        n = 0;
        repeat (9) begin
            @(posedge clk);
            #1;
            if (valid_o) n++;
        end
        @(negedge clk);
        flush_i = 1'b1;
        @(posedge clk);
        #1;
        flush_i = 1'b0;
        check("flush_busy.ready", 64'(ready_o), 64'd1);
        repeat (40) begin
            @(posedge clk);
            #1;
            if (valid_o) n++;
        end
        check("flush_busy.pulses", 64'(n), 64'd0);
        do_test("after_flush", MULTU_L, 32'd3, 32'd4, 7'd31, 32'd12, 6'b011100, 34, 1'b0);

        // Flush in DONE suppresses the pulse
        @(negedge clk);
        valid_i  = 1'b1;
        opcode_i = SYSCALL;
        tag_i    = 7'd40;
        @(posedge clk);
        #1;
        valid_i = 1'b0;
        flush_i = 1'b1;
        @(posedge clk);
        #1;
        flush_i = 1'b0;
        check("flush_done.valid", 64'(valid_o), 64'd0);
        check("flush_done.ready", 64'(ready_o), 64'd1);
        check("flush_done.tag",   64'(tag_o),   64'd31);

        // Flush together with an offer in IDLE: nothing accepted
        @(negedge clk);
        valid_i  = 1'b1;
        flush_i  = 1'b1;
        opcode_i = SYSCALL;
        tag_i    = 7'd41;
        @(posedge clk);
        #1;
        valid_i = 1'b0;
        flush_i = 1'b0;
        check("flush_idle.ready", 64'(ready_o), 64'd1);
        n = 0;
        repeat (5) begin
            @(posedge clk);
            #1;
            if (valid_o) n++;
        end
        check("flush_idle.pulses", 64'(n), 64'd0);

        // Asynchronous reset in the middle of a multiply clears all outputs
        @(negedge clk);
        valid_i  = 1'b1;
        opcode_i = MULT_L;
        data1_i  = 32'd9;
        data2_i  = 32'd9;
        tag_i    = 7'd50;
        @(posedge clk);
        #1;
        valid_i = 1'b0;
        repeat (5) @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        check("rst_mid.ready",  64'(ready_o),  64'd1);
        check("rst_mid.valid",  64'(valid_o),  64'd0);
        check("rst_mid.result", 64'(result_o), 64'd0);
        check("rst_mid.flags",  64'(flags_o),  64'd0);
        check("rst_mid.tag",    64'(tag_o),    64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        n = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (valid_o) n++;
        end
        check("rst_mid.pulses", 64'(n), 64'd0);
        do_test("after_rst", MULTU_H, 32'h0001_0000, 32'h0003_0000, 7'd51, 32'd3, 6'b010100, 34, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
